// File: rtl/core_run_ctrl.sv
// Run-control for the single-cycle core: debounced RUN/STEP keys sequence the
// core clock-enable through HALT, RUN, STEP and PC-breakpoint modes.
module core_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          START_RUNNING   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_key_run_n,
  input  logic        i_key_step_n,
  input  logic        i_bp_en,
  input  logic [31:0] i_bp_addr,
  input  logic [31:0] i_pc_debug,
  input  logic        i_insn_vld,
  output logic        o_core_en,
  output logic [1:0]  o_state,
  output logic        o_bp_hit,
  output logic [31:0] o_retired_cnt
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  // Bit 0 is the RUN key, bit 1 the STEP key; levels are kept active-low.
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [1:0]    r_press;
  logic [CW-1:0] r_cnt [2];

  state_t        r_state;
  logic          r_skip;
  logic          r_bp_hit;
  logic [31:0]   r_retired_cnt;

  logic          w_hit;
  logic          w_core_en;
  logic          w_run_press;
  logic          w_step_press;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '1;
      r_press <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_sync1 <= {i_key_step_n, i_key_run_n};
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_db[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_MAX) begin
          // Accept the new level; only a released->pressed change yields a pulse.
          r_db[k]    <= r_sync2[k];
          r_cnt[k]   <= '0;
          r_press[k] <= ~r_sync2[k];
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_run_press  = r_press[0];
  assign w_step_press = r_press[1];

  always_comb begin
    w_hit     = i_bp_en & (i_pc_debug == i_bp_addr) & ~r_skip;
    w_core_en = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_RUN:   w_core_en = ~w_hit;
        S_STEP:  w_core_en = 1'b1;
        default: w_core_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= START_RUNNING ? S_RUN : S_HALT;
      r_skip        <= 1'b0;
      r_bp_hit      <= 1'b0;
      r_retired_cnt <= '0;
    end else begin
      if (w_core_en && i_insn_vld) begin
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
      if (w_core_en) begin
        r_skip <= 1'b0;
      end
      r_bp_hit <= 1'b0;
      case (r_state)
        S_HALT, S_BREAK: begin
          if (w_run_press) begin
            r_state <= S_RUN;
            r_skip  <= 1'b1;
          end else if (w_step_press) begin
            r_state <= S_STEP;
            r_skip  <= 1'b1;
          end else if (r_state == S_BREAK) begin
            r_bp_hit <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_hit) begin
            r_state  <= S_BREAK;
            r_bp_hit <= 1'b1;
          end else if (w_run_press) begin
            r_state <= S_HALT;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign o_core_en     = w_core_en;
  assign o_state       = r_state;
  assign o_bp_hit      = r_bp_hit;
  assign o_retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed and randomized bench for core_run_ctrl against a behavioural model
// of key debouncing, run-mode sequencing and instruction retirement.
module tb_core_run_ctrl;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_run_n, key_step_n, bp_en, vld;
  logic [31:0] bp_addr, pc;
  logic        core_en, bp_hit;
  logic [1:0]  state;
  logic [31:0] retired;

  core_run_ctrl #(.DEBOUNCE_CYCLES(D), .START_RUNNING(1'b0)) dut (
    .i_clk(clk), .i_reset(rst), .i_key_run_n(key_run_n), .i_key_step_n(key_step_n),
    .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_pc_debug(pc), .i_insn_vld(vld),
    .o_core_en(core_en), .o_state(state), .o_bp_hit(bp_hit), .o_retired_cnt(retired)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int en_seen  = 0;
  bit auto_pc  = 1'b0;

  // Model: mode 0=HALT 1=RUN 2=STEP 3=BREAK, plus raw key history per key.
  int          m_state;
  bit          m_skip, m_bp;
  logic [31:0] m_cnt;
  bit          m_db    [2];
  bit          m_press [2];
  bit          hist    [2][D+2];

  task automatic m_reset();
    m_state = 0; m_skip = 0; m_bp = 0; m_cnt = '0;
    for (int k = 0; k < 2; k++) begin
      m_db[k] = 1; m_press[k] = 0;
      for (int a = 0; a < D + 2; a++) hist[k][a] = 1;
    end
  endtask

  function automatic bit m_hit();
    return bp_en && (pc == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_en();
    if (rst) return 1'b0;
    return (m_state == 1 && !m_hit()) || m_state == 2;
  endfunction

  task automatic m_clock();
    bit en, hit, set_skip, stable;
    bit raw [2];
    int nxt;
    en = m_en(); hit = m_hit(); nxt = m_state; set_skip = 0;
    if (m_state == 0 || m_state == 3) begin
      if (m_press[0]) begin nxt = 1; set_skip = 1; end
      else if (m_press[1]) begin nxt = 2; set_skip = 1; end
    end else if (m_state == 1) begin
      if (hit) nxt = 3;
      else if (m_press[0]) nxt = 0;
    end else begin
      nxt = 0;
    end
    if (en) m_skip = 0;
    else if (set_skip) m_skip = 1;
    if (en && vld) m_cnt = m_cnt + 32'd1;
    m_bp = (nxt == 3);
    m_state = nxt;
    // A level is accepted once D consecutive synchronized samples disagree with it.
    raw[0] = key_run_n; raw[1] = key_step_n;
    for (int k = 0; k < 2; k++) begin
      for (int a = D + 1; a > 0; a--) hist[k][a] = hist[k][a-1];
      hist[k][0] = raw[k];
      m_press[k] = 0;
      stable = 1;
      for (int a = 2; a < D + 2; a++) if (hist[k][a] == m_db[k]) stable = 0;
      if (stable) begin
        m_db[k] = !m_db[k];
        m_press[k] = !m_db[k];
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit en_was;
    #1;
    check("core_en", 32'(core_en), 32'(m_en()));
    check("state", 32'(state), 32'(m_state));
    check("bp_hit", 32'(bp_hit), 32'(m_bp));
    check("retired", retired, m_cnt);
    if (core_en === 1'b1) en_seen++;
    en_was = m_en();
    @(posedge clk);
    if (rst) m_reset(); else m_clock();
    @(negedge clk);
    if (auto_pc && en_was) pc = pc + 32'd4;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1; key_run_n = 1; key_step_n = 1; bp_en = 0; bp_addr = '0; pc = '0;
    auto_pc = 0; m_reset();
    ticks(2);
    rst = 0;
  endtask

  task automatic press(input bit run, input bit step, input int hold, input int rel);
    if (run) key_run_n = 0;
    if (step) key_step_n = 0;
    ticks(hold);
    key_run_n = 1; key_step_n = 1;
    ticks(rel);
  endtask

  int lat, rl, sl;

  initial begin
    rst = 1; key_run_n = 1; key_step_n = 1; bp_en = 0; bp_addr = '0; pc = '0; vld = 1;
    m_reset();
    @(negedge clk);

    // 1: glitches shorter than the debounce window
    do_reset();
    for (int i = 0; i < 4; i++) press(1, 0, 2, 3);
    ticks(6);
    check("glitch_state", 32'(state), 32'd0);
    check("glitch_retired", retired, 32'd0);

    // 2: clean press enters RUN 7 cycles after the raw edge, second press halts
    key_run_n = 0;
    lat = 0;
    while (state !== 2'd1 && lat < 20) begin tick(); lat++; end
    check("run_latency", 32'(lat), 32'd7);
    ticks(13);
    key_run_n = 1;
    ticks(6);
    press(1, 0, 8, 10);
    check("halt_state", 32'(state), 32'd0);
    ticks(5);

    // 3: two single steps
    do_reset();
    en_seen = 0;
    press(0, 1, 8, 8);
    press(0, 1, 8, 8);
    check("step_en_cycles", 32'(en_seen), 32'd2);
    check("step_retired", retired, 32'd2);
    check("step_state", 32'(state), 32'd0);

    // 4: breakpoint at 0x10, then resume past it
    do_reset();
    bp_en = 1; bp_addr = 32'h10; auto_pc = 1;
    key_run_n = 0;
    lat = 0;
    while (state !== 2'd3 && lat < 40) begin
      if (lat == 8) key_run_n = 1;
      tick(); lat++;
    end
    key_run_n = 1;
    check("bp_state", 32'(state), 32'd3);
    check("bp_hit_flag", 32'(bp_hit), 32'd1);
    check("bp_retired", retired, 32'd4);
    ticks(3);
    press(1, 0, 8, 6);
    check("resume_state", 32'(state), 32'd1);
    check("resume_pc_past_bp", 32'(pc > 32'h14), 32'd1);

    // 5: simultaneous RUN+STEP picks RUN; counter wraps
    do_reset();
    press(1, 1, 8, 4);
    check("both_keys_state", 32'(state), 32'd1);
    #1 force dut.r_retired_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_retired_cnt;
    m_cnt = 32'hFFFF_FFFE;
    ticks(3);
    #1;
    check("wrap_retired", retired, 32'h0000_0001);
    @(negedge clk);

    // 6: asynchronous reset during a STEP debounce
    do_reset();
    press(1, 0, 8, 4);
    key_step_n = 0;
    ticks(3);
    #2 rst = 1;
    #1;
    m_reset();
    check("async_core_en", 32'(core_en), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_retired", retired, 32'd0);
    key_step_n = 1;
    @(negedge clk);
    tick();
    rst = 0;
    ticks(12);
    check("post_reset_state", 32'(state), 32'd0);

    // Randomized keys, breakpoints and PC flow
    do_reset();
    auto_pc = 1; rl = 0; sl = 0;
    for (int i = 0; i < 600; i++) begin
      if (rl == 0) begin key_run_n = 1'($urandom_range(0, 1)); rl = $urandom_range(1, 10); end
      if (sl == 0) begin key_step_n = 1'($urandom_range(0, 1)); sl = $urandom_range(1, 10); end
      rl--; sl--;
      if ($urandom_range(0, 40) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 60) == 0) bp_addr = 32'($urandom_range(0, 11)) << 2;
      if (pc >= 32'h30) pc = '0;
      vld = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
